pipe_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the five-stage pipeline. It holds or bubbles the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers and the PC for three events:
- data-memory wait states, tracked by a small FSM with timeout;
- load-use hazards;
- control-flow redirects resolved in EX.

It also keeps a saturating stall-cycle counter for performance debug.

---
 rtl/pipe_hazard_ctrl.sv | 135 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush sequencer: memory wait-state freeze with timeout,
// load-use bubble insertion, EX redirect squash, and a saturating stall counter.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ID_rs1,
  input  logic [4:0]  ID_rs2,
  input  logic [4:0]  EX_rd,
  input  logic [1:0]  EX_WDSel,
  input  logic        EX_RegWrite,
  input  logic        EX_redirect,
  input  logic        MEM_dm_req,
  input  logic        dm_ready,
  output logic        PC_stall,
  output logic        IF_ID_stall,
  output logic        IF_ID_flush,
  output logic        ID_EX_stall,
  output logic        ID_EX_flush,
  output logic        EX_MEM_stall,
  output logic        MEM_WB_flush,
  output logic        dm_timeout,
  output logic [31:0] stall_cycles
);

  // state       | meaning
  // ST_RUN      | normal flow; hazard logic active
  // ST_MEM_WAIT | data memory stalled, pipeline frozen, wcnt counting
  // ST_TIMEOUT  | memory never answered; frozen until reset
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_TIMEOUT  = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  state_t      state_q, state_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic        dm_timeout_q, dm_timeout_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic        mem_freeze;
  logic        load_use;

  // A load in EX whose destination feeds the ID instruction; x0 never hazards.
  assign load_use = (EX_WDSel == 2'b01) && EX_RegWrite && (EX_rd != 5'd0) &&
                    ((EX_rd == ID_rs1) || (EX_rd == ID_rs2));

  // Next-state logic and memory-freeze decision.
  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    mem_freeze = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (MEM_dm_req && !dm_ready) begin
          mem_freeze = 1'b1;
          state_d    = ST_MEM_WAIT;
          wcnt_d     = 8'd1;
        end
      end
      ST_MEM_WAIT: begin
        if (dm_ready) begin
          state_d = ST_RUN;
          wcnt_d  = 8'd0;
        end else begin
          mem_freeze = 1'b1;
          wcnt_d     = wcnt_q + 8'd1;
          if (wcnt_q == TIMEOUT_CNT) state_d = ST_TIMEOUT;
        end
      end
      ST_TIMEOUT: begin
        mem_freeze = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
        wcnt_d  = 8'd0;
      end
    endcase
  end

  // Control outputs: freeze beats redirect beats load-use. The release cycle of
  // a wait is not frozen, so hazards are naturally re-evaluated there.
  always_comb begin
    PC_stall     = 1'b0;
    IF_ID_stall  = 1'b0;
    IF_ID_flush  = 1'b0;
    ID_EX_stall  = 1'b0;
    ID_EX_flush  = 1'b0;
    EX_MEM_stall = 1'b0;
    MEM_WB_flush = 1'b0;
    if (mem_freeze) begin
      PC_stall     = 1'b1;
      IF_ID_stall  = 1'b1;
      ID_EX_stall  = 1'b1;
      EX_MEM_stall = 1'b1;
      MEM_WB_flush = 1'b1;
    end else if (EX_redirect) begin
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
    end else if (load_use) begin
      PC_stall    = 1'b1;
      IF_ID_stall = 1'b1;
      ID_EX_flush = 1'b1;
    end
  end

  // Sticky timeout flag (set on the edge that enters TIMEOUT) and saturating counter.
  always_comb begin
    dm_timeout_d   = dm_timeout_q | (state_d == ST_TIMEOUT);
    stall_cycles_d = stall_cycles_q;
    if (PC_stall && (stall_cycles_q != 32'hFFFF_FFFF))
      stall_cycles_d = stall_cycles_q + 32'd1;
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_RUN;
      wcnt_q         <= 8'd0;
      dm_timeout_q   <= 1'b0;
      stall_cycles_q <= 32'd0;
    end else begin
      state_q        <= state_d;
      wcnt_q         <= wcnt_d;
      dm_timeout_q   <= dm_timeout_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign dm_timeout   = dm_timeout_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned MT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  ID_rs1 = '0, ID_rs2 = '0, EX_rd = '0;
  logic [1:0]  EX_WDSel = '0;
  logic        EX_RegWrite = 1'b0, EX_redirect = 1'b0, MEM_dm_req = 1'b0, dm_ready = 1'b0;
  logic        PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush;
  logic        EX_MEM_stall, MEM_WB_flush, dm_timeout;
  logic [31:0] stall_cycles;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(MT)) dut (
    .clk(clk), .reset(reset),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .EX_rd(EX_rd), .EX_WDSel(EX_WDSel),
    .EX_RegWrite(EX_RegWrite), .EX_redirect(EX_redirect),
    .MEM_dm_req(MEM_dm_req), .dm_ready(dm_ready),
    .PC_stall(PC_stall), .IF_ID_stall(IF_ID_stall), .IF_ID_flush(IF_ID_flush),
    .ID_EX_stall(ID_EX_stall), .ID_EX_flush(ID_EX_flush),
    .EX_MEM_stall(EX_MEM_stall), .MEM_WB_flush(MEM_WB_flush),
    .dm_timeout(dm_timeout), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a wait is "in progress" iff the previous cycle was frozen; timeout
  // happens once MT+1 consecutive freeze cycles have elapsed.
  bit          m_prev_frz = 1'b0;
  bit          m_to = 1'b0;
  int          m_streak = 0;
  logic [63:0] m_cnt = '0;

  function automatic bit m_freeze();
    return m_to || ((m_prev_frz || MEM_dm_req) && !dm_ready);
  endfunction

  // {PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush, EX_MEM_stall, MEM_WB_flush}
  function automatic logic [6:0] m_ctrl();
    bit frz, lu, rd;
    frz = m_freeze();
    lu  = (EX_WDSel == 2'b01) && EX_RegWrite && (EX_rd != 0) &&
          (EX_rd == ID_rs1 || EX_rd == ID_rs2);
    rd  = !frz && EX_redirect;
    lu  = !frz && !EX_redirect && lu;
    return {frz || lu, frz || lu, rd, frz, rd || lu, frz, frz};
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_prev_frz <= 1'b0;
      m_to       <= 1'b0;
      m_streak   <= 0;
      m_cnt      <= '0;
    end else begin
      logic [6:0] c;
      bit frz;
      c   = m_ctrl();
      frz = m_freeze();
      m_prev_frz <= frz;
      m_streak   <= frz ? m_streak + 1 : 0;
      if (frz && (m_streak + 1 >= int'(MT) + 1)) m_to <= 1'b1;
      if (c[6] && m_cnt < 64'hFFFF_FFFF) m_cnt <= m_cnt + 1;
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [6:0] e;
      e = m_ctrl();
      chk("PC_stall",     {31'd0, PC_stall},     {31'd0, e[6]});
      chk("IF_ID_stall",  {31'd0, IF_ID_stall},  {31'd0, e[5]});
      chk("IF_ID_flush",  {31'd0, IF_ID_flush},  {31'd0, e[4]});
      chk("ID_EX_stall",  {31'd0, ID_EX_stall},  {31'd0, e[3]});
      chk("ID_EX_flush",  {31'd0, ID_EX_flush},  {31'd0, e[2]});
      chk("EX_MEM_stall", {31'd0, EX_MEM_stall}, {31'd0, e[1]});
      chk("MEM_WB_flush", {31'd0, MEM_WB_flush}, {31'd0, e[0]});
      chk("dm_timeout",   {31'd0, dm_timeout},   {31'd0, m_to});
      chk("stall_cycles", stall_cycles,          m_cnt[31:0]);
    end
  end

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [1:0] wds, input logic rw, input logic redir,
                       input logic req, input logic rdy);
    ID_rs1 = rs1; ID_rs2 = rs2; EX_rd = rd; EX_WDSel = wds;
    EX_RegWrite = rw; EX_redirect = redir; MEM_dm_req = req; dm_ready = rdy;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ctrl_vec();
    return {25'd0, PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall,
            ID_EX_flush, EX_MEM_stall, MEM_WB_flush};
  endfunction

  initial begin
    int nfrz, nflush;
    idle();
    #2;
    chk("reset_ctrl", ctrl_vec(), 32'd0);
    chk("reset_timeout", {31'd0, dm_timeout}, 32'd0);
    chk("reset_count", stall_cycles, 32'd0);
    tick();
    reset = 1'b0;
    chk_en = 1'b1;

    // Load-use on rs2.
    drive(5'd0, 5'd5, 5'd5, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    chk("lu_pc_stall", {31'd0, PC_stall}, 32'd1);
    chk("lu_ctrl", ctrl_vec(), 32'b1100100);
    tick();
    idle();
    #2;
    chk("lu_count", stall_cycles, 32'd1);
    chk("lu_one_bubble", {31'd0, PC_stall}, 32'd0);
    tick();

    // x0 destination never hazards.
    drive(5'd0, 5'd0, 5'd0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    chk("lu_x0", ctrl_vec(), 32'd0);
    tick();

    // Redirect suppresses load-use.
    drive(5'd0, 5'd5, 5'd5, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
    #2;
    chk("redir_lu_ctrl", ctrl_vec(), 32'b0010100);
    tick();
    idle();
    #2;
    chk("redir_count", stall_cycles, 32'd1);
    tick();

    // Memory wait of three cycles with redirect masked until release.
    nfrz = 0;
    nflush = 0;
    for (int i = 0; i < 4; i++) begin
      drive(5'd0, 5'd0, 5'd0, 2'd0, 1'b0, 1'b1, 1'b1, (i == 3));
      #2;
      if (i < 3) begin
        nfrz   += int'(PC_stall && EX_MEM_stall && MEM_WB_flush);
        nflush += int'(IF_ID_flush || ID_EX_flush);
      end else begin
        chk("release_ctrl", ctrl_vec(), 32'b0010100);
      end
      tick();
    end
    chk("wait_freeze_cycles", nfrz, 32'd3);
    chk("wait_masked_flush", nflush, 32'd0);
    idle();
    #2;
    chk("wait_count", stall_cycles, 32'd4);
    tick();

    // Saturation.
    chk_en = 1'b0;
    force dut.stall_cycles_q = 32'hFFFF_FFFE;
    tick();
    release dut.stall_cycles_q;
    m_cnt = 64'hFFFF_FFFE;
    chk_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(5'd0, 5'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1, (i == 3));
      tick();
    end
    idle();
    #2;
    chk("saturate", stall_cycles, 32'hFFFF_FFFF);
    tick();

    // Timeout after MT+1 freeze cycles, then reset clears everything.
    drive(5'd0, 5'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      #2;
      if (i == 4) chk("pre_timeout", {31'd0, dm_timeout}, 32'd0);
      if (i == 5) chk("timeout_set", {31'd0, dm_timeout}, 32'd1);
      if (i == 7) begin
        chk("timeout_sticky", {31'd0, dm_timeout}, 32'd1);
        chk("timeout_freeze", ctrl_vec(), 32'b1101011);
      end
      if (i == 6) dm_ready = 1'b1;
      tick();
    end
    reset = 1'b1;
    idle();
    #2;
    chk("rst_ctrl", ctrl_vec(), 32'd0);
    chk("rst_timeout", {31'd0, dm_timeout}, 32'd0);
    chk("rst_count", stall_cycles, 32'd0);
    tick();
    reset = 1'b0;

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) < ((n / 500) % 2 == 0 ? 6 : 3)));
      reset = ($urandom_range(0, 149) == 0);
      tick();
    end
    reset = 1'b0;
    idle();
    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
